nerv_dmem_responder: RTL

Data-memory responder for the nerv core's `dmem_*` port, i.e. the memory side of the interface the core drives as initiator. Serves word-organised RAM reads and byte-strobed writes, inserts a programmable number of wait states through `stall`, and flags out-of-range accesses. It also emits one-cycle memory-access event records, so simulation benches and formal harnesses get a responder-side view of every completed access.

---
 rtl/nerv_dmem_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/nerv_dmem_responder.sv
// nerv_dmem_responder
// Memory side of the nerv core's dmem_* port. It serves word-organised RAM
// reads and byte-strobed writes, and inserts LATENCY wait states through
// `stall`. An access outside [BASE, BASE + DEPTH*4) is dropped and produces a
// one-cycle `dmem_fault` pulse. Every completed access also emits a one-cycle
// read or write event record.
//
// Parameters: DEPTH (RAM words, power of two >= 4), BASE (byte address of
//             word 0), LATENCY (wait states, 0..15)
// Ports:
//   clock, reset (async, active low)
//   dmem_valid, dmem_addr, dmem_wstrb, dmem_wdata   request from the core
//   stall                                           holds the core while high
//   dmem_rdata, dmem_fault                          registered response
//   mem_read_*  / mem_write_*                       completion event records
module nerv_dmem_responder #(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int          LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_wdata,
  output logic        stall,
  output logic [31:0] dmem_rdata,
  output logic        dmem_fault,
  output logic        mem_read_valid,
  output logic [31:0] mem_read_addr,
  output logic [6:0]  mem_read_memWidth,
  output logic [31:0] mem_read_data,
  output logic        mem_write_valid,
  output logic [31:0] mem_write_addr,
  output logic [6:0]  mem_write_memWidth,
  output logic [31:0] mem_write_data
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam bit          HAS_WAIT = (LATENCY > 0);
  localparam logic [3:0]  CNT_INIT = HAS_WAIT ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        done;

  // Completing access: the live request when there are no wait states,
  // otherwise the copy latched on entry to BUSY.
  logic [31:0] c_addr, c_wdata, off;
  logic [3:0]  c_wstrb;
  logic        in_range, is_rd;
  logic [AW-1:0] idx;
  logic [31:0] rd_word;

  logic [31:0] ram [DEPTH];

  function automatic logic [6:0] width_of(input logic [3:0] s);
    logic [2:0] n;
    n = 3'(s[0]) + 3'(s[1]) + 3'(s[2]) + 3'(s[3]);
    return {1'b0, n, 3'b000};
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (dmem_valid && HAS_WAIT) begin
        state_nxt = BUSY;
        cnt_nxt   = CNT_INIT;
      end
      BUSY: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            else             state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs of the FSM. In the BUSY->IDLE cycle dmem_valid is still high for
  // the same request; `done` comes from the BUSY term only, so it is not
  // accepted a second time. Gating with reset keeps an aborted access from
  // touching the RAM.
  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE: begin
        stall = dmem_valid && HAS_WAIT;
        done  = dmem_valid && !HAS_WAIT && reset;
      end
      BUSY: begin
        stall = (cnt != 4'd0);
        done  = (cnt == 4'd0) && reset;
      end
      default: ;
    endcase
  end

  // Request latch
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_addr  <= 32'd0;
      req_wstrb <= 4'd0;
      req_wdata <= 32'd0;
    end else if (state == IDLE && dmem_valid && HAS_WAIT) begin
      req_addr  <= dmem_addr;
      req_wstrb <= dmem_wstrb;
      req_wdata <= dmem_wdata;
    end
  end

  always_comb begin
    c_addr   = (state == BUSY) ? req_addr  : dmem_addr;
    c_wstrb  = (state == BUSY) ? req_wstrb : dmem_wstrb;
    c_wdata  = (state == BUSY) ? req_wdata : dmem_wdata;
    // Unsigned wrap: addresses below BASE become huge offsets, so they fall
    // out of range.
    off      = c_addr - BASE;
    in_range = ({1'b0, off} < SPAN);
    idx      = off[AW+1:2];
    is_rd    = (c_wstrb == 4'd0);
    rd_word  = ram[idx];
  end

  // RAM has no reset, so its power-up contents are undefined.
  always_ff @(posedge clock) begin
    if (done && in_range) begin
      for (int i = 0; i < 4; i++)
        if (c_wstrb[i]) ram[idx][8*i +: 8] <= c_wdata[8*i +: 8];
    end
  end

  // Response and event records
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dmem_rdata         <= 32'd0;
      dmem_fault         <= 1'b0;
      mem_read_valid     <= 1'b0;
      mem_read_addr      <= 32'd0;
      mem_read_memWidth  <= 7'd0;
      mem_read_data      <= 32'd0;
      mem_write_valid    <= 1'b0;
      mem_write_addr     <= 32'd0;
      mem_write_memWidth <= 7'd0;
      mem_write_data     <= 32'd0;
    end else begin
      dmem_fault      <= done && !in_range;
      mem_read_valid  <= done && is_rd;
      mem_write_valid <= done && !is_rd;
      if (done && is_rd) begin
        dmem_rdata        <= in_range ? rd_word : 32'd0;
        mem_read_addr     <= c_addr;
        mem_read_memWidth <= 7'd32;
        mem_read_data     <= in_range ? rd_word : 32'd0;
      end
      if (done && !is_rd) begin
        mem_write_addr     <= c_addr;
        mem_write_memWidth <= width_of(c_wstrb);
        mem_write_data     <= c_wdata;
      end
    end
  end

endmodule
